// File: rtl/conv_pool_requant_if.sv
// Pixel stream bundle for conv_pool_requant.
// Carries the NUM_TREES x 32-bit accumulator beat coming in and the
// NUM_TREES x 8-bit pooled, requantized pixel going out.
// The producer/consumer side uses master; the pooling block uses slave.
interface conv_pool_requant_if #(
    parameter int NUM_TREES = 2
);
    logic [32*NUM_TREES-1:0] pixel_vector_in;
    logic                    valid_in;
    logic [8*NUM_TREES-1:0]  pixel_vector_out;
    logic                    valid_out;

    modport master (
        output pixel_vector_in,
        output valid_in,
        input  pixel_vector_out,
        input  valid_out
    );

    modport slave (
        input  pixel_vector_in,
        input  valid_in,
        output pixel_vector_out,
        output valid_out
    );
endinterface

// File: rtl/conv_pool_requant.sv
// conv_pool_requant: streaming 2x2 stride-2 max pool followed by an
// arithmetic right shift and 8-bit saturation, one lane per channel.
// Input is one conv output pixel per valid beat in raster order; a pooled
// pixel is emitted on every odd-column beat of an odd row.
//
// Build option: define CONV_POOL_RELU_EN for ReLU saturation to 0..255
// (unsigned output); leave it undefined for signed saturation to -128..127.
module conv_pool_requant #(
    parameter int NUM_TREES = 2,
    parameter int ROW_WIDTH = 8,
    parameter int SHIFT     = 8
) (
    input  logic              clock,
    input  logic              reset,
    conv_pool_requant_if.slave bus
);

    localparam int HALF  = ROW_WIDTH / 2;
    localparam int COL_W = (ROW_WIDTH > 2) ? $clog2(ROW_WIDTH) : 1;
    localparam int IDX_W = (HALF > 1) ? $clog2(HALF) : 1;

    typedef enum logic {
        ROW_EVEN = 1'b0,
        ROW_ODD  = 1'b1
    } row_state_t;

    row_state_t              row_state_q;
    logic [COL_W-1:0]        col_q;
    logic [IDX_W-1:0]        lb_idx;
    logic                    last_col;

    logic signed [31:0]      sample   [NUM_TREES];
    logic signed [31:0]      pair_p0  [NUM_TREES];
    logic signed [31:0]      hmax     [NUM_TREES];
    logic signed [31:0]      vmax     [NUM_TREES];
    logic [7:0]              q_req    [NUM_TREES];
    logic signed [31:0]      lbuf     [HALF][NUM_TREES];

    logic [8*NUM_TREES-1:0]  pix_p1;
    logic                    vld_p1;

    function automatic logic signed [31:0] smax(input logic signed [31:0] a,
                                                input logic signed [31:0] b);
        return (a > b) ? a : b;
    endfunction

    // Arithmetic shift then clamp to the 8-bit output range of this build.
    function automatic logic [7:0] requant(input logic signed [31:0] v);
        logic signed [31:0] q;
        q = v >>> SHIFT;
`ifdef CONV_POOL_RELU_EN
        if (q < 0)
            return 8'h00;
        else if (q > 32'sd255)
            return 8'hFF;
        else
            return q[7:0];
`else
        if (q < -32'sd128)
            return 8'h80;
        else if (q > 32'sd127)
            return 8'h7F;
        else
            return q[7:0];
`endif
    endfunction

    assign last_col = (col_q == COL_W'(ROW_WIDTH - 1));
    assign lb_idx   = IDX_W'(col_q >> 1);

    // Per-lane horizontal max, vertical max against the line buffer, requant.
    always_comb begin
        for (int k = 0; k < NUM_TREES; k++) begin
            sample[k] = $signed(bus.pixel_vector_in[32*k +: 32]);
            hmax[k]   = smax(pair_p0[k], sample[k]);
            vmax[k]   = smax(lbuf[lb_idx][k], hmax[k]);
            q_req[k]  = requant(vmax[k]);
        end
    end

    // Position tracking, row-parity FSM, pair registers and output register.
    always_ff @(posedge clock) begin
        if (!reset) begin
            col_q       <= '0;
            row_state_q <= ROW_EVEN;
            vld_p1      <= 1'b0;
            pix_p1      <= '0;
            for (int k = 0; k < NUM_TREES; k++)
                pair_p0[k] <= '0;
        end else begin
            vld_p1 <= 1'b0;
            if (bus.valid_in) begin
                col_q <= last_col ? '0 : col_q + 1'b1;
                if (last_col)
                    row_state_q <= (row_state_q == ROW_EVEN) ? ROW_ODD : ROW_EVEN;
                if (!col_q[0]) begin
                    for (int k = 0; k < NUM_TREES; k++)
                        pair_p0[k] <= sample[k];
                end else if (row_state_q == ROW_ODD) begin
                    for (int k = 0; k < NUM_TREES; k++)
                        pix_p1[8*k +: 8] <= q_req[k];
                    vld_p1 <= 1'b1;
                end
            end
        end
    end

    // Even-row horizontal maxima park in the line buffer; never cleared,
    // every entry is rewritten in the even row before the odd row reads it.
    always_ff @(posedge clock) begin
        if (reset && bus.valid_in && col_q[0] && row_state_q == ROW_EVEN) begin
            for (int k = 0; k < NUM_TREES; k++)
                lbuf[lb_idx][k] <= hmax[k];
        end
    end

    assign bus.pixel_vector_out = pix_p1;
    assign bus.valid_out        = vld_p1;

endmodule

// File: doc/conv_pool_requant.md
# conv_pool_requant

Streaming 2x2 max-pool and requantization stage that sits directly downstream of `convolution_25D`. It takes that block's NUM_TREES parallel 32-bit signed accumulator outputs, one conv output pixel per valid beat in raster order. Each channel is reduced by a 2x2 stride-2 max pool, then arithmetically shifted and saturated to 8 bits. The result is an 8-bit-per-channel pixel vector sized to drive the `pixel_vector_in` of the next `convolution_25D` layer, whose Z_DEPTH equals NUM_TREES.

## Interface
- NUM_TREES, 2, channels (kernels) per beat; one pool lane per channel
- ROW_WIDTH, 8, conv output pixels per row; must be even and ≥2
- SHIFT, 8, requantization right-shift amount; 0..31

- clock  in  1  single clock, rising edge
- reset  in  1  synchronous, active-low; sampled on rising edge of clock
- pixel_vector_in  in  32*NUM_TREES  channel k at [32k+31:32k], signed two's complement
- valid_in  in  1  qualifies pixel_vector_in for this cycle
- pixel_vector_out  out  8*NUM_TREES  channel k at [8k+7:8k], registered
- valid_out  out  1  one-cycle strobe; pixel_vector_out holds a new pooled pixel

## Operation
- Position tracking uses a column counter `col` (0..ROW_WIDTH-1) and a row-parity FSM.
  - The FSM has two states, ROW_EVEN and ROW_ODD.
  - On each beat with valid_in=1, `col` increments.
  - When `col`=ROW_WIDTH-1, `col` wraps to 0 and the FSM toggles state.
  - When valid_in=0, `col`, the FSM, and all data registers hold.
- Horizontal stage, per channel:
  - On a beat with `col` even, the sample is latched into a pair register.
  - On a beat with `col` odd, hmax = signed max(pair register, current sample) is formed.
- ROW_EVEN, `col` odd: hmax is written to the line buffer at entry `col`>>1. The line buffer has ROW_WIDTH/2 entries × NUM_TREES × 32 bits. No output is produced.
- ROW_ODD, `col` odd:
  - vmax = signed max(line buffer[`col`>>1], hmax).
  - vmax is requantized and registered to pixel_vector_out.
  - valid_out is asserted on the next cycle.
- Requantization, per channel:
  - q = vmax >>> SHIFT (arithmetic shift).
  - q is saturated to the 8-bit range defined under Configuration.
  - Comparisons are full 32-bit signed; no intermediate overflow is possible.
- Output rate: exactly ROW_WIDTH/2 output pixels per odd row. There are no outputs during even rows.
- No backpressure. The downstream stage must accept every valid_out strobe.

## Timing
- Reset values:
  - pixel_vector_out = 0, valid_out = 0.
  - `col` = 0, FSM = ROW_EVEN, pair registers = 0.
  - Line buffer is not cleared. Every entry is rewritten in ROW_EVEN before it is read.
- Latency: valid_out rises exactly 1 cycle after the rising edge that samples the completing beat (ROW_ODD, `col` odd).
- valid_out is high for exactly 1 cycle per pooled pixel.
- pixel_vector_out holds its last value until the next strobe.
- Back-to-back: with valid_in continuously high, valid_out is high on every second cycle during the odd row, alternating with low cycles.
- Gaps: valid_in may drop between any two beats, including between the two halves of a horizontal pair. The pooled result is identical to the gap-free case.
- Reset mid-frame:
  - The partial window is discarded.
  - valid_out is 0 on the cycle after reset is sampled low, even if a completing beat was in flight.
  - The next valid beat is treated as row 0, col 0.
- Reset has priority over valid_in in the same cycle.

## Configuration
- CONV_POOL_RELU_EN
  - Defined: ReLU saturation. q<0 → 0x00; q>255 → 0xFF. Output is unsigned 0..255, matching the unsigned pixel inputs of the next layer.
  - Undefined: signed saturation. q<-128 → 0x80; q>127 → 0x7F. Output is two's complement.
- Pooling and timing are identical in both builds.

## Test plan
All scenarios use NUM_TREES=2, ROW_WIDTH=4, SHIFT=2, and run after reset unless stated.

- Ramp, continuous valid_in.
  - Channel 0 gets 0,16,32,…,112 (16×beat index); channel 1 gets 2× channel 0.
  - Required: valid_out 1 cycle after beats 6 and 8.
  - Channel 0 outputs are 20 then 28. Channel 1 outputs are 40 then 56.
  - No valid_out during beats 1–4.
- Mixed-sign max.
  - Window {-5, 100 / -200, 7} on channel 0.
  - Required: vmax=100, output 25 in both builds.
- Saturation.
  - All window samples 2000 → 500 after shift.
  - Required: 0xFF with CONV_POOL_RELU_EN; 0x7F without.
  - All samples -400 → -100 after shift.
  - Required: 0x00 with the macro; 0x9C without.
- Gapped valid_in.
  - Repeat the ramp with 3 idle cycles after every beat.
  - Required: same output values (20/28, 40/56), each 1 cycle after beats 6 and 8.
  - pixel_vector_out holds stable during gaps.
- Reset mid-frame.
  - Assert reset low for 1 cycle after beat 5 of the ramp, then stream a fresh ramp.
  - Required: no valid_out from the aborted frame; the fresh frame yields 20/28 on channel 0.
- Two-frame continuity with ROW_WIDTH=4.
  - Stream 16 beats (4 rows).
  - Required: 4 strobes, after beats 6, 8, 14, 16.
  - The FSM returns to ROW_EVEN after beat 16.
